// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the MIPS core front end: fetch-unit state encoding,
//   the opcode constants the front end cares about, instruction field slice
//   positions and a helper that forms the byte offset of a branch.
//   No ports (package).
// -----------------------------------------------------------------------------
package mips_pkg;

  // Fetch-unit states.
  //   RST  : one idle cycle after reset, no request issued
  //   REQ  : one-cycle request pulse to instruction memory
  //   WAIT : waiting for the memory response strobe
  //   HOLD : instruction held for decode/execute until retire
  typedef enum logic [1:0] {
    RST  = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ifu_state_e;

  // Opcodes the front end and decoder share.
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  // Instruction field slice positions.
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int JIDX_MSB   = 25;
  localparam int JIDX_LSB   = 0;

  // Sign-extended word offset of a branch, already scaled to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage : mips_pkg

// File: rtl/next_pc_calc.sv
// -----------------------------------------------------------------------------
// next_pc_calc
//   Purely combinational next-PC selection for a retiring instruction.
//   Shared between the single-cycle fetch unit and the later pipelined core.
//
// Ports
//   pc      in  32  address of the retiring instruction
//   instr   in  32  the retiring instruction word
//   jump    in  1   decoder says unconditional jump
//   branch  in  1   decoder says conditional branch
//   zero    in  1   ALU zero flag (branch condition)
//   next_pc out 32  address of the following instruction
//
// Priority: jump > taken branch > sequential. All arithmetic wraps mod 2^32.
// -----------------------------------------------------------------------------
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic [31:0] p4;
  logic [31:0] jump_target;
  logic [31:0] branch_target;

  // The opcode field is decoded upstream; only the index/immediate matter here.
  logic unused_opcode;
  assign unused_opcode = ^instr[OPCODE_MSB:OPCODE_LSB];

  // NOTE: every variable written in an always_comb gets a default at the top,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    p4            = pc + 32'd4;
    // Jump keeps the region (top nibble) of the sequential address.
    jump_target   = {p4[31:28], instr[JIDX_MSB:JIDX_LSB], 2'b00};
    branch_target = p4 + branch_offset(instr[IMM_MSB:IMM_LSB]);

    next_pc = p4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = branch_target;
    end
  end

endmodule : next_pc_calc

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Front end of the single-cycle MIPS core. Owns the PC, fetches one
//   instruction at a time from instruction memory over a request/response
//   handshake of variable latency (>= 1 cycle), holds the word stable for
//   decode/execute until retire, then advances the PC via next_pc_calc.
//
// Parameters
//   RESET_PC  PC loaded on reset (word aligned, bits [1:0] = 0)
//   TIMEOUT   WAIT cycles before a fetch is abandoned and re-issued (>= 2);
//             only meaningful when IFETCH_TIMEOUT_EN is defined
//
// Ports
//   clk          in  1   clock, rising edge
//   rst          in  1   synchronous, active-high reset
//   imem_req     out 1   one-cycle request pulse
//   imem_addr    out 32  fetch address (always equals pc)
//   imem_rvalid  in  1   response strobe
//   imem_rdata   in  32  instruction word, sampled with imem_rvalid
//   instr        out 32  held instruction (instr[31:26] feeds the decoder)
//   instr_valid  out 1   instr is valid for decode/execute
//   pc           out 32  address of instr
//   retire       in  1   current instruction completes this cycle
//   jump         in  1   from decoder, sampled on retire
//   branch       in  1   from decoder, sampled on retire
//   zero         in  1   ALU zero flag, sampled on retire
//   fetch_err    out 1   sticky fetch timeout (IFETCH_TIMEOUT_EN only)
//
// Build option
//   IFETCH_TIMEOUT_EN  adds a WAIT-cycle counter, the fetch_err port and
//                      re-issue of the same pc on timeout. Without it WAIT
//                      waits indefinitely.
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  input  logic        retire,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero
`ifdef IFETCH_TIMEOUT_EN
  ,
  output logic        fetch_err
`endif
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] next_pc;

`ifdef IFETCH_TIMEOUT_EN
  // Counts WAIT cycles 0 .. TIMEOUT-1; TIMEOUT >= 2 keeps the width >= 1.
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fetch_err_q, fetch_err_d;
`else
  // TIMEOUT has no effect in this build.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  next_pc_calc u_next_pc_calc (
    .pc      (pc_q),
    .instr   (instr_q),
    .jump    (jump),
    .branch  (branch),
    .zero    (zero),
    .next_pc (next_pc)
  );

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    imem_req      = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
    cnt_d         = cnt_q;
    fetch_err_d   = fetch_err_q;
`endif

    unique case (state_q)
      RST: begin
        state_d = REQ;
      end

      // Any rvalid seen here belongs to an earlier or aborted request.
      REQ: begin
        imem_req = 1'b1;
        state_d  = WAIT;
`ifdef IFETCH_TIMEOUT_EN
        cnt_d    = '0;
`endif
      end

      WAIT: begin
        if (imem_rvalid) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = HOLD;
        end
`ifdef IFETCH_TIMEOUT_EN
        // The last permitted WAIT cycle passed without a response:
        // flag it and re-issue the same pc.
        else if (cnt_q == CNT_LAST) begin
          fetch_err_d = 1'b1;
          state_d     = REQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      // jump/branch/zero only matter on the retire edge.
      HOLD: begin
        if (retire) begin
          pc_d          = next_pc;
          instr_valid_d = 1'b0;
          state_d       = REQ;
        end
      end

      default: begin
        state_d = RST;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RST;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

`ifdef IFETCH_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign fetch_err = fetch_err_q;
`endif

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit. Three instances differ only in
//   RESET_PC (0x0, 0x4000_0000, 0xFFFF_FFFC) so that region jumps and PC
//   wrap-around can be reached directly. Expected fetch addresses and
//   instruction words go into queues as stimulus is driven and are popped
//   when the DUT issues a request or raises instr_valid.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_fetch_unit;
  import mips_pkg::*;

  localparam int NDUT       = 3;
  localparam int TO         = 4;
  localparam int REQ_BUDGET = 50;

  function automatic logic [31:0] rpc_of(input int k);
    case (k)
      0:       return 32'h0000_0000;
      1:       return 32'h4000_0000;
      default: return 32'hFFFF_FFFC;
    endcase
  endfunction

  logic        clk;
  logic        rst         [NDUT];
  logic        imem_req    [NDUT];
  logic [31:0] imem_addr   [NDUT];
  logic        imem_rvalid [NDUT];
  logic [31:0] imem_rdata  [NDUT];
  logic [31:0] instr       [NDUT];
  logic        instr_valid [NDUT];
  logic [31:0] pc          [NDUT];
  logic        retire      [NDUT];
  logic        jump        [NDUT];
  logic        branch      [NDUT];
  logic        zero        [NDUT];
`ifdef IFETCH_TIMEOUT_EN
  logic        fetch_err   [NDUT];
`endif

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    instr_fetch_unit #(
      .RESET_PC (rpc_of(g)),
      .TIMEOUT  (TO)
    ) u_dut (
      .clk         (clk),
      .rst         (rst[g]),
      .imem_req    (imem_req[g]),
      .imem_addr   (imem_addr[g]),
      .imem_rvalid (imem_rvalid[g]),
      .imem_rdata  (imem_rdata[g]),
      .instr       (instr[g]),
      .instr_valid (instr_valid[g]),
      .pc          (pc[g]),
      .retire      (retire[g]),
      .jump        (jump[g]),
      .branch      (branch[g]),
      .zero        (zero[g])
`ifdef IFETCH_TIMEOUT_EN
      ,
      .fetch_err   (fetch_err[g])
`endif
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_addr_q  [$];
  logic [31:0] exp_instr_q [$];
  logic [31:0] model_pc;
  logic [31:0] model_instr;

  // Independent reference for the next-PC rule.
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ins,
                                             input logic j, input logic b, input logic z);
    logic [31:0] seq;
    int          off;
    seq = p + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ({6'b0, ins[25:0]} << 2);
    if (b && z) begin
      off = int'(signed'(ins[15:0]));
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a request pulse and compare its address with the queue.
  task automatic expect_req(input int k);
    logic [31:0] exp_a;
    int n;
    n = 0;
    while (imem_req[k] !== 1'b1 && n < REQ_BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", 32'(imem_req[k]), 32'd1);
    exp_a = exp_addr_q.pop_front();
    check("imem_addr", imem_addr[k], exp_a);
    check("pc_eq_addr", pc[k], exp_a);
  endtask

  // Answer the outstanding request after lat cycles; optionally pulse retire
  // meanwhile, which must have no effect.
  task automatic respond(input int k, input int lat, input logic [31:0] data, input logic poke);
    for (int i = 0; i < lat; i++) begin
      retire[k] = poke;
      @(negedge clk);
      check("valid_low_wait", 32'(instr_valid[k]), 32'd0);
      check("pc_hold_wait", pc[k], model_pc);
    end
    retire[k]      = 1'b0;
    imem_rvalid[k] = 1'b1;
    imem_rdata[k]  = data;
    exp_instr_q.push_back(data);
    @(negedge clk);
    imem_rvalid[k] = 1'b0;
    imem_rdata[k]  = $urandom();
    check("valid_high", 32'(instr_valid[k]), 32'd1);
    check("instr", instr[k], exp_instr_q.pop_front());
    check("pc_at_valid", pc[k], model_pc);
    model_instr = data;
  endtask

  task automatic serve(input int k, input int lat, input logic [31:0] data, input logic poke);
    expect_req(k);
    respond(k, lat, data, poke);
  endtask

  // Sit in HOLD; with noise set, jump/branch/zero toggle without retire.
  task automatic hold(input int k, input int cyc, input logic noise);
    for (int i = 0; i < cyc; i++) begin
      jump[k]   = noise;
      branch[k] = noise;
      zero[k]   = noise;
      @(negedge clk);
      check("hold_valid", 32'(instr_valid[k]), 32'd1);
      check("hold_instr", instr[k], model_instr);
      check("hold_pc", pc[k], model_pc);
    end
    jump[k]   = 1'b0;
    branch[k] = 1'b0;
    zero[k]   = 1'b0;
  endtask

  task automatic do_retire(input int k, input logic j, input logic b, input logic z);
    logic [31:0] nxt;
    retire[k] = 1'b1;
    jump[k]   = j;
    branch[k] = b;
    zero[k]   = z;
    nxt       = model_next(model_pc, model_instr, j, b, z);
    exp_addr_q.push_back(nxt);
    model_pc  = nxt;
    @(negedge clk);
    retire[k] = 1'b0;
    jump[k]   = 1'b0;
    branch[k] = 1'b0;
    zero[k]   = 1'b0;
    check("valid_drop", 32'(instr_valid[k]), 32'd0);
  endtask

  task automatic do_reset(input int k);
    rst[k] = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req", 32'(imem_req[k]), 32'd0);
    check("rst_instr", instr[k], 32'd0);
    check("rst_valid", 32'(instr_valid[k]), 32'd0);
    check("rst_pc", pc[k], rpc_of(k));
`ifdef IFETCH_TIMEOUT_EN
    check("rst_fetch_err", 32'(fetch_err[k]), 32'd0);
`endif
    rst[k] = 1'b0;
    check("rst_cycle_no_req", 32'(imem_req[k]), 32'd0);
    exp_addr_q.push_back(rpc_of(k));
    model_pc = rpc_of(k);
    @(negedge clk);
    check("req_2nd_cycle", 32'(imem_req[k]), 32'd1);
  endtask

  logic [31:0] beq_w;
  logic [31:0] j1_w;
  logic [31:0] j2_w;

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      rst[k]         = 1'b1;
      imem_rvalid[k] = 1'b0;
      imem_rdata[k]  = 32'd0;
      retire[k]      = 1'b0;
      jump[k]        = 1'b0;
      branch[k]      = 1'b0;
      zero[k]        = 1'b0;
    end
    beq_w = {OP_BEQ, 5'd1, 5'd2, 16'hFFFF};
    j1_w  = {OP_J, 26'h000_0010};
    j2_w  = {OP_J, 26'h000_0100};
    repeat (2) @(negedge clk);

    // ---- DUT 0: RESET_PC = 0 -------------------------------------------------
    do_reset(0);
    serve(0, 1, 32'h8C01_0004, 1'b0);        // lw, latency 1
    do_retire(0, 1'b0, 1'b0, 1'b0);          // -> 0x4
    serve(0, 3, 32'h8C02_0008, 1'b1);        // latency 3, early retire ignored
    hold(0, 3, 1'b0);
    do_retire(0, 1'b0, 1'b0, 1'b0);          // -> 0x8
    serve(0, 3, 32'h0022_1820, 1'b0);
    do_retire(0, 1'b0, 1'b0, 1'b0);          // -> 0xC
    serve(0, 2, 32'h2063_0001, 1'b0);
    do_retire(0, 1'b0, 1'b0, 1'b0);          // -> 0x10
    serve(0, 1, beq_w, 1'b0);
    do_retire(0, 1'b0, 1'b1, 1'b1);          // taken, imm -1 -> 0x10
    serve(0, 2, beq_w, 1'b0);
    do_retire(0, 1'b0, 1'b1, 1'b0);          // not taken -> 0x14
    expect_req(0);
`ifdef IFETCH_TIMEOUT_EN
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      check("err_low_wait", 32'(fetch_err[0]), 32'd0);
      check("no_req_wait", 32'(imem_req[0]), 32'd0);
    end
    @(negedge clk);
    check("fetch_err_set", 32'(fetch_err[0]), 32'd1);
    exp_addr_q.push_back(32'h0000_0014);
    expect_req(0);                           // same pc re-issued
`endif
    respond(0, 2, 32'h0000_0000, 1'b0);
`ifdef IFETCH_TIMEOUT_EN
    check("fetch_err_sticky", 32'(fetch_err[0]), 32'd1);
    do_reset(0);
    expect_req(0);
`endif
    rst[0] = 1'b1;

    // ---- DUT 1: RESET_PC = 0x4000_0000 ---------------------------------------
    do_reset(1);
    serve(1, 1, j1_w, 1'b0);
    do_retire(1, 1'b1, 1'b0, 1'b0);          // -> 0x4000_0040
    serve(1, 2, j2_w, 1'b0);
    do_retire(1, 1'b1, 1'b1, 1'b1);          // jump beats taken branch -> 0x4000_0400
    serve(1, 1, j2_w, 1'b0);
    hold(1, 2, 1'b1);                        // decoder inputs toggling without retire
    do_retire(1, 1'b0, 1'b0, 1'b0);          // sequential -> 0x4000_0404
    expect_req(1);
    rst[1] = 1'b1;

    // ---- DUT 2: RESET_PC = 0xFFFF_FFFC ---------------------------------------
    do_reset(2);
    serve(2, 1, 32'h0000_0020, 1'b0);
    do_retire(2, 1'b0, 1'b0, 1'b0);          // wraps -> 0x0
    expect_req(2);
    @(negedge clk);                          // now in WAIT
    rst[2] = 1'b1;
    @(negedge clk);
    check("abort_valid", 32'(instr_valid[2]), 32'd0);
    check("abort_req", 32'(imem_req[2]), 32'd0);
    check("abort_pc", pc[2], rpc_of(2));
    rst[2]         = 1'b0;
    imem_rvalid[2] = 1'b1;                   // late response of the aborted fetch
    imem_rdata[2]  = 32'hDEAD_BEEF;
    exp_addr_q.push_back(rpc_of(2));
    model_pc = rpc_of(2);
    @(negedge clk);
    expect_req(2);
    @(negedge clk);
    imem_rvalid[2] = 1'b0;
    check("late_rvalid_dropped", 32'(instr_valid[2]), 32'd0);
    respond(2, 1, 32'h2108_0001, 1'b0);
    rst[2] = 1'b1;

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_instr_fetch_unit
